hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised forwarding and hazard-control unit for the 5-stage pipeline; successor to `forwarding_unit`. Selects ALU-operand and store-data bypass paths for N source operands, detects load-use hazards, and inserts a configurable number of bubbles. Freezes the whole pipeline while data memory is busy and keeps a saturating stall-cycle counter. Sits beside the D/X, X/M and M/W pipeline registers and drives their stall/flush controls.

## Interface
Parameters:
- ADDR_W, 4, register address width (2^ADDR_W registers)
- NUM_SRC, 2, source operands per instruction (1..4)
- LU_BUBBLES, 1, bubbles per load-use hazard (1..3)
- CNT_W, 16, stall counter width
- ZERO_REG, 1, when 1, register 0 is hardwired zero: never forwarded, never a hazard

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- fd_src  in  NUM_SRC*ADDR_W  D-stage source addresses; slice i = bits [i*ADDR_W +: ADDR_W]
- fd_src_vld  in  NUM_SRC  D-stage source i is read
- dx_src  in  NUM_SRC*ADDR_W  X-stage source addresses, same packing
- dx_src_vld  in  NUM_SRC  X-stage source i is read
- dx_rd, dx_regwrite, dx_memread  in  ADDR_W,1,1  X-stage destination/controls
- xm_rd, xm_rt  in  ADDR_W each  X/M destination; store-data register
- xm_regwrite, xm_memread, xm_memwrite  in  1 each  X/M controls
- mw_rd, mw_regwrite  in  ADDR_W,1  M/W destination/control
- dmem_busy  in  1  data memory not ready this cycle
- cnt_clr  in  1  synchronous clear of stall_cnt
- fwd_sel  out  NUM_SRC*2  per-source bypass select
- fwd_store  out  1  store data taken from M/W
- pc_stall, fd_stall  out  1 each  hold PC and F/D register
- dx_flush  out  1  load bubble into D/X
- freeze  out  1  hold D/X, X/M, M/W registers
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating

## Operation
- Match(a,b): a==b and (ZERO_REG==0 or a!=0).
- fwd_sel[i] (combinational): 00 when !dx_src_vld[i]; 10 when xm_regwrite & !xm_memread & Match(xm_rd,src_i); else 01 when mw_regwrite & Match(mw_rd,src_i); else 00. X/M beats M/W.
- fwd_store = xm_memwrite & mw_regwrite & Match(mw_rd,xm_rt).
- Load-use hazard lu_hit = dx_memread & dx_regwrite & OR over i of (fd_src_vld[i] & Match(dx_rd,fd_src_i)).
- FSM states RUN, LU_STALL, MEM_WAIT; 2-bit bubble counter bub.
- RUN: dmem_busy -> MEM_WAIT (bub=0). Else lu_hit -> pc_stall=fd_stall=dx_flush=1 this cycle; if LU_BUBBLES>1 -> LU_STALL, bub=LU_BUBBLES-1; else stay RUN.
- LU_STALL: dmem_busy -> MEM_WAIT, bub held. Else pc_stall=fd_stall=dx_flush=1, bub decrements; bub reaching 0 -> RUN.
- MEM_WAIT: pc_stall=fd_stall=freeze=1, dx_flush=0. When dmem_busy drops -> LU_STALL if bub!=0 else RUN; exit cycle has freeze=0.
- dmem_busy is also honoured combinationally in RUN/LU_STALL: freeze, pc_stall and fd_stall assert the same cycle and dx_flush is forced 0.
- freeze has priority over dx_flush in every state.
- stall_cnt: cnt_clr -> 0 (priority). Else +1 when pc_stall=1, holding at 2^CNT_W-1.

## Timing
- Reset: state RUN, bub=0, stall_cnt=0. pc_stall, fd_stall, dx_flush and freeze are forced 0 while rst is high. fwd_sel and fwd_store stay combinational.
- Reset asserted mid-stall or mid-MEM_WAIT aborts immediately; first cycle after release is RUN.
- Forwarding and stall outputs are combinational, zero latency. State, bub and stall_cnt update on the rising clk edge.
- A load-use hazard costs exactly LU_BUBBLES stall cycles plus any dmem_busy cycles.
- stall_cnt reflects the previous cycle's pc_stall, i.e. one-cycle lag.

## Test plan
- dx_src0=1 (vld), xm_rd=1/xm_regwrite=1, mw_rd=1/mw_regwrite=1 -> fwd_sel[1:0]=10. Set xm_memread=1 -> 01. Set both regwrites 0 -> 00. src=0 with ZERO_REG=1 -> 00.
- dx_memread=dx_regwrite=1, dx_rd=3, fd_src1=3 vld, LU_BUBBLES=2 -> pc_stall/fd_stall/dx_flush high 2 consecutive cycles, then low. stall_cnt=2.
- Same hazard with dmem_busy raised in the second bubble for 3 cycles -> freeze=1, dx_flush=0 for 3 cycles, then 1 remaining bubble, then RUN. stall_cnt=5.
- xm_memwrite=1, xm_rt=5, mw_rd=5, mw_regwrite=1 -> fwd_store=1. mw_rd=0 -> 0.
- CNT_W=3, hold dmem_busy 10 cycles -> stall_cnt saturates at 7. cnt_clr pulse -> 0 the next cycle.
- rst pulsed while in LU_STALL -> all stall outputs 0 immediately; stall_cnt=0; next hazard handled normally from RUN.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Forwarding and hazard-control unit for the 5-stage pipeline: operand/store bypass
// selection, load-use bubble insertion, data-memory freeze and a saturating stall counter.
module hazard_fwd_unit #(
    parameter int ADDR_W     = 4,
    parameter int NUM_SRC    = 2,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16,
    parameter int ZERO_REG   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*ADDR_W-1:0]   fd_src,
    input  logic [NUM_SRC-1:0]          fd_src_vld,
    input  logic [NUM_SRC*ADDR_W-1:0]   dx_src,
    input  logic [NUM_SRC-1:0]          dx_src_vld,
    input  logic [ADDR_W-1:0]           dx_rd,
    input  logic                        dx_regwrite,
    input  logic                        dx_memread,
    input  logic [ADDR_W-1:0]           xm_rd,
    input  logic [ADDR_W-1:0]           xm_rt,
    input  logic                        xm_regwrite,
    input  logic                        xm_memread,
    input  logic                        xm_memwrite,
    input  logic [ADDR_W-1:0]           mw_rd,
    input  logic                        mw_regwrite,
    input  logic                        dmem_busy,
    input  logic                        cnt_clr,
    output logic [NUM_SRC*2-1:0]        fwd_sel,
    output logic                        fwd_store,
    output logic                        pc_stall,
    output logic                        fd_stall,
    output logic                        dx_flush,
    output logic                        freeze,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [1:0]         bub_q, bub_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lu_hit;

    function automatic logic match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a == b) && ((ZERO_REG == 0) || (a != '0));
    endfunction

    // X/M result beats M/W; a load in X/M has no data yet, so it never forwards.
    always_comb begin
        fwd_sel = '0;
        lu_hit  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (dx_src_vld[i]) begin
                if (xm_regwrite && !xm_memread && match(xm_rd, dx_src[i*ADDR_W +: ADDR_W]))
                    fwd_sel[i*2 +: 2] = 2'b10;
                else if (mw_regwrite && match(mw_rd, dx_src[i*ADDR_W +: ADDR_W]))
                    fwd_sel[i*2 +: 2] = 2'b01;
            end
            if (fd_src_vld[i] && match(dx_rd, fd_src[i*ADDR_W +: ADDR_W]))
                lu_hit = 1'b1;
        end
        lu_hit = lu_hit && dx_memread && dx_regwrite;
    end

    assign fwd_store = xm_memwrite && mw_regwrite && match(mw_rd, xm_rt);

    always_comb begin
        state_d  = state_q;
        bub_d    = bub_q;
        pc_stall = 1'b0;
        dx_flush = 1'b0;
        freeze   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dmem_busy) begin
                    pc_stall = 1'b1;
                    freeze   = 1'b1;
                    state_d  = MEM_WAIT;
                    bub_d    = 2'd0;
                end else if (lu_hit) begin
                    pc_stall = 1'b1;
                    dx_flush = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_d = LU_STALL;
                        bub_d   = 2'(LU_BUBBLES - 1);
                    end
                end
            end
            LU_STALL: begin
                if (dmem_busy) begin
                    pc_stall = 1'b1;
                    freeze   = 1'b1;
                    state_d  = MEM_WAIT;
                end else begin
                    pc_stall = 1'b1;
                    dx_flush = 1'b1;
                    bub_d    = bub_q - 2'd1;
                    if (bub_q == 2'd1) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                // The cycle dmem_busy drops is a plain transition: nothing stalled.
                if (dmem_busy) begin
                    pc_stall = 1'b1;
                    freeze   = 1'b1;
                end else begin
                    state_d = (bub_q != 2'd0) ? LU_STALL : RUN;
                end
            end
            default: begin
                state_d = RUN;
                bub_d   = 2'd0;
            end
        endcase
        if (rst) begin
            pc_stall = 1'b0;
            dx_flush = 1'b0;
            freeze   = 1'b0;
        end
    end

    assign fd_stall = pc_stall;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (pc_stall && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            bub_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed scenarios plus random traffic,
// checked against a bubble-count model of the stall behaviour.
module tb_hazard_fwd_unit;

    localparam int ADDR_W     = 4;
    localparam int NUM_SRC    = 2;
    localparam int LU_BUBBLES = 2;
    localparam int CNT_W      = 3;
    localparam int ZERO_REG   = 1;
    localparam int EW         = NUM_SRC*2 + 5 + CNT_W;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC*ADDR_W-1:0] fd_src, dx_src;
    logic [NUM_SRC-1:0]        fd_src_vld, dx_src_vld;
    logic [ADDR_W-1:0]         dx_rd, xm_rd, xm_rt, mw_rd;
    logic                      dx_regwrite, dx_memread;
    logic                      xm_regwrite, xm_memread, xm_memwrite, mw_regwrite;
    logic                      dmem_busy, cnt_clr;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      fwd_store, pc_stall, fd_stall, dx_flush, freeze;
    logic [CNT_W-1:0]          stall_cnt;
    logic [1:0]                dbg_state;

    hazard_fwd_unit #(
        .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LU_BUBBLES(LU_BUBBLES),
        .CNT_W(CNT_W), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .rst(rst),
        .fd_src(fd_src), .fd_src_vld(fd_src_vld),
        .dx_src(dx_src), .dx_src_vld(dx_src_vld),
        .dx_rd(dx_rd), .dx_regwrite(dx_regwrite), .dx_memread(dx_memread),
        .xm_rd(xm_rd), .xm_rt(xm_rt),
        .xm_regwrite(xm_regwrite), .xm_memread(xm_memread), .xm_memwrite(xm_memwrite),
        .mw_rd(mw_rd), .mw_regwrite(mw_regwrite),
        .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_sel), .fwd_store(fwd_store),
        .pc_stall(pc_stall), .fd_stall(fd_stall), .dx_flush(dx_flush), .freeze(freeze),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- scoreboard state ----
    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    // Reference model: bubbles still owed, whether a memory wait is in progress,
    // and the stall count as a plain integer.
    int m_rem  = 0;
    bit m_wait = 1'b0;
    int m_cnt  = 0;

    function automatic bit same_reg(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        if (ZERO_REG != 0 && a == 0) return 1'b0;
        return a == b;
    endfunction

    task automatic clear_inputs();
        rst = 1'b0; fd_src = '0; fd_src_vld = '0; dx_src = '0; dx_src_vld = '0;
        dx_rd = '0; dx_regwrite = 1'b0; dx_memread = 1'b0;
        xm_rd = '0; xm_rt = '0; xm_regwrite = 1'b0; xm_memread = 1'b0; xm_memwrite = 1'b0;
        mw_rd = '0; mw_regwrite = 1'b0; dmem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compute this cycle's expected outputs from the current inputs and queue them.
    task automatic issue();
        logic [NUM_SRC*2-1:0] e_sel;
        logic [CNT_W-1:0]     e_cnt;
        bit e_store, e_stall, e_flush, e_freeze, hit;
        e_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [ADDR_W-1:0] s;
            s = dx_src[i*ADDR_W +: ADDR_W];
            if (!dx_src_vld[i])                                   e_sel[i*2 +: 2] = 2'b00;
            else if (xm_regwrite && !xm_memread && same_reg(xm_rd, s)) e_sel[i*2 +: 2] = 2'b10;
            else if (mw_regwrite && same_reg(mw_rd, s))            e_sel[i*2 +: 2] = 2'b01;
        end
        e_store = xm_memwrite && mw_regwrite && same_reg(mw_rd, xm_rt);
        hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (fd_src_vld[i] && same_reg(dx_rd, fd_src[i*ADDR_W +: ADDR_W])) hit = 1'b1;
        hit = hit && dx_memread && dx_regwrite;

        if (rst) begin
            m_rem = 0; m_wait = 1'b0; m_cnt = 0;
        end
        e_cnt = CNT_W'(m_cnt);
        e_stall = 1'b0; e_flush = 1'b0; e_freeze = 1'b0;
        if (rst) begin
        end else if (dmem_busy) begin
            e_stall = 1'b1; e_freeze = 1'b1; m_wait = 1'b1;
        end else if (m_wait) begin
            m_wait = 1'b0;
        end else if (m_rem > 0) begin
            e_stall = 1'b1; e_flush = 1'b1; m_rem--;
        end else if (hit) begin
            e_stall = 1'b1; e_flush = 1'b1; m_rem = LU_BUBBLES - 1;
        end
        if (rst || cnt_clr) m_cnt = 0;
        else if (e_stall)   m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;

        exp_q.push_back({e_sel, e_store, e_stall, e_stall, e_flush, e_freeze, e_cnt});
    endtask

    task automatic step();
        issue();
        tick();
    endtask

    // ---- monitor: outputs are combinational, so every cycle presents a result ----
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e, got;
            e   = exp_q.pop_front();
            got = {fwd_sel, fwd_store, pc_stall, fd_stall, dx_flush, freeze, stall_cnt};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL outputs vec %0d t=%0t: got sel=%b st=%b pc=%b fd=%b fl=%b fz=%b cnt=%0d, exp sel=%b st=%b pc=%b fd=%b fl=%b fz=%b cnt=%0d",
                         n_vec, $time,
                         got[EW-1 -: NUM_SRC*2], got[CNT_W+4], got[CNT_W+3], got[CNT_W+2],
                         got[CNT_W+1], got[CNT_W], got[CNT_W-1:0],
                         e[EW-1 -: NUM_SRC*2], e[CNT_W+4], e[CNT_W+3], e[CNT_W+2],
                         e[CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
            end
        end
    end

    task automatic set_hazard();
        dx_memread = 1'b1; dx_regwrite = 1'b1; dx_rd = 4'd3;
        fd_src[1*ADDR_W +: ADDR_W] = 4'd3; fd_src_vld[1] = 1'b1;
    endtask

    // ---- driver ----
    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();

        // reset
        for (int k = 0; k < 3; k++) begin rst = 1'b1; step(); end
        rst = 1'b0;

        // operand forwarding priorities
        dx_src[0 +: ADDR_W] = 4'd1; dx_src_vld[0] = 1'b1;
        xm_rd = 4'd1; xm_regwrite = 1'b1; mw_rd = 4'd1; mw_regwrite = 1'b1; step();
        xm_memread = 1'b1; step();
        xm_regwrite = 1'b0; mw_regwrite = 1'b0; step();
        xm_memread = 1'b0; xm_regwrite = 1'b1; mw_regwrite = 1'b1;
        xm_rd = 4'd0; mw_rd = 4'd0; dx_src[0 +: ADDR_W] = 4'd0; step();
        xm_rd = 4'd7; mw_rd = 4'd2; dx_src[0 +: ADDR_W] = 4'd2;
        dx_src[ADDR_W +: ADDR_W] = 4'd7; dx_src_vld = 2'b11; step();
        clear_inputs();

        // plain load-use hazard: two bubbles
        set_hazard(); step(); step();
        clear_inputs(); step(); step();

        // hazard with a 3-cycle memory wait in the second bubble
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        set_hazard(); step();
        dmem_busy = 1'b1; step(); step(); step();
        clear_inputs(); step(); step(); step(); step();

        // store-data forwarding
        xm_memwrite = 1'b1; xm_rt = 4'd5; mw_rd = 4'd5; mw_regwrite = 1'b1; step();
        xm_rt = 4'd0; mw_rd = 4'd0; step();
        clear_inputs();

        // counter saturation and clear
        dmem_busy = 1'b1;
        for (int k = 0; k < 10; k++) step();
        dmem_busy = 1'b0; step(); step();
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0; step();

        // reset in the middle of a load-use stall
        set_hazard(); step();
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        clear_inputs(); step(); step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                fd_src[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
                dx_src[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
            end
            fd_src_vld  = NUM_SRC'($urandom);
            dx_src_vld  = NUM_SRC'($urandom);
            dx_rd       = ADDR_W'($urandom_range(0, 3));
            xm_rd       = ADDR_W'($urandom_range(0, 3));
            xm_rt       = ADDR_W'($urandom_range(0, 3));
            mw_rd       = ADDR_W'($urandom_range(0, 3));
            dx_regwrite = ($urandom_range(0, 3) != 0);
            dx_memread  = ($urandom_range(0, 2) == 0);
            xm_regwrite = $urandom_range(0, 1) == 1;
            xm_memread  = ($urandom_range(0, 3) == 0);
            xm_memwrite = $urandom_range(0, 1) == 1;
            mw_regwrite = $urandom_range(0, 1) == 1;
            dmem_busy   = ($urandom_range(0, 7) == 0);
            cnt_clr     = ($urandom_range(0, 31) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            step();
        end
        clear_inputs();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
